// File: rtl/simple_module.sv
// simple_module: enabled running-XOR (parity) accumulator.
// Each enabled clock folds d into q, so q holds the running parity of every
// d sampled since reset or power-up. Each bit of d/q is an independent lane.
// Optional feature: define SIMPLE_MODULE_TOGGLE_CNT_EN to add the toggle_cnt
// output, a 16-bit wrapping count of updates that changed q.
module simple_module #(
    parameter int unsigned          WIDTH    = 1,
    parameter logic [WIDTH-1:0]     INIT_VAL = '0,
    localparam int unsigned         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
`ifdef SIMPLE_MODULE_TOGGLE_CNT_EN
    output logic [CNT_W-1:0] toggle_cnt,
`endif
    output logic [WIDTH-1:0] q
);

    // The declaration initialiser gives the power-up value, so the block
    // works even if rst is never asserted.
    logic [WIDTH-1:0] q_r = INIT_VAL;

    // Parity state: reset wins over enable, enabled edges XOR d in.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= INIT_VAL;
        end else if (en) begin
            q_r <= q_r ^ d;
        end
    end

    assign q = q_r;

`ifdef SIMPLE_MODULE_TOGGLE_CNT_EN
    logic [CNT_W-1:0] cnt_r = '0;

    // Toggle counter: q changes exactly when an enabled update has d != 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (en && (d != '0)) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign toggle_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_simple_module.sv
// tb_simple_module: directed self-checking bench for simple_module.
// Covers power-up value, running XOR, hold, reset priority, a 4-bit lane
// instance with non-zero INIT_VAL, and (when SIMPLE_MODULE_TOGGLE_CNT_EN is
// defined) the toggle counter including wrap.
module tb_simple_module;

    logic       clk = 1'b0;
    logic       rst1 = 1'b0, en1 = 1'b0;
    logic [0:0] d1 = '0;
    logic [0:0] q1;
    logic       rst4 = 1'b0, en4 = 1'b0;
    logic [3:0] d4 = '0;
    logic [3:0] q4;
`ifdef SIMPLE_MODULE_TOGGLE_CNT_EN
    logic [15:0] cnt1;
    logic [15:0] cnt4;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    simple_module #(.WIDTH(1), .INIT_VAL(1'b0)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .d(d1),
`ifdef SIMPLE_MODULE_TOGGLE_CNT_EN
        .toggle_cnt(cnt1),
`endif
        .q(q1)
    );

    simple_module #(.WIDTH(4), .INIT_VAL(4'hA)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .d(d4),
`ifdef SIMPLE_MODULE_TOGGLE_CNT_EN
        .toggle_cnt(cnt4),
`endif
        .q(q4)
    );

    // Advance one rising edge and settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [4:0]  seq1 = 5'b01101;          // applied LSB first: 1,0,1,1,0
    logic [11:0] seq2 = 12'b1011_0010_1101; // applied LSB first
    logic        qm;

    initial begin
        // Power-up values, no reset ever applied to dut1 before test 1
        #1;
        chk("pwrup_q1", 16'(q1), 16'h0);
        chk("pwrup_q4", 16'(q4), 16'hA);

        // Test 1: running XOR from power-up; expected 1,1,0,1,1
        en1 = 1'b1;
        qm  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d1 = seq1[i];
            qm = qm ^ seq1[i];
            step();
            chk($sformatf("t1_edge%0d", i), 16'(q1), 16'(qm));
        end

        // Test 2: 12-edge stream against the reference model
        for (int i = 0; i < 12; i++) begin
            d1 = seq2[i];
            qm = qm ^ seq2[i];
            step();
            chk($sformatf("t2_edge%0d", i), 16'(q1), 16'(qm));
        end
        // Seven ones in seq2 starting from q=1 leave q=0
        chk("t2_final", 16'(q1), 16'h0);

        // Test 3: set q=1 then hold with en=0, d=1
        d1 = 1'b1;
        step();
        chk("t3_set", 16'(q1), 16'h1);
        en1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t3_hold%0d", i), 16'(q1), 16'h1);
        end

        // Test 4: reset wins over en/d, then accumulation restarts
        en1 = 1'b1; d1 = 1'b1; rst1 = 1'b1;
        step();
        chk("t4_rst", 16'(q1), 16'h0);
        rst1 = 1'b0;
        step();
        chk("t4_release", 16'(q1), 16'h1);
        d1 = 1'b0;
        step();
        chk("t4_d0", 16'(q1), 16'h1);

        // Test 5: 4-bit lanes with INIT_VAL=A
        en4 = 1'b1; d4 = 4'hF;
        step();
        chk("t5_pre_rst", 16'(q4), 16'h5);
        rst4 = 1'b1;
        step();
        chk("t5_rst", 16'(q4), 16'hA);
        rst4 = 1'b0; d4 = 4'hF;
        step();
        chk("t5_invert", 16'(q4), 16'h5);
        d4 = 4'h3;
        step();
        chk("t5_xor3", 16'(q4), 16'h6);
        d4 = 4'h0;
        step();
        chk("t5_d0", 16'(q4), 16'h6);
        en4 = 1'b0; d4 = 4'hF;
        step();
        chk("t5_hold", 16'(q4), 16'h6);

`ifdef SIMPLE_MODULE_TOGGLE_CNT_EN
        // Test 6: toggle counter, clear, count, wrap
        rst1 = 1'b1; en1 = 1'b1; d1 = 1'b1;
        step();
        chk("t6_clear", cnt1, 16'h0);
        rst1 = 1'b0;
        d1 = 1'b1; step();
        d1 = 1'b0; step();
        d1 = 1'b1; step();
        chk("t6_cnt2", cnt1, 16'h2);
        chk("t6_q", 16'(q1), 16'h0);
        d1 = 1'b1;
        for (int i = 0; i < 65533; i++) step();
        chk("t6_ffff", cnt1, 16'hFFFF);
        step();
        chk("t6_wrap", cnt1, 16'h0);
        en1 = 1'b0;
        step();
        chk("t6_hold", cnt1, 16'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
